// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve / play / point / game-over FSM with score keeping and winner decision.
// Optional macro PONG_WIN_BY_TWO_EN switches the win condition to "reach WIN_SCORE with a lead of two".
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       paddle_en,
  output logic       ball_en,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [3:0] WIN4       = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);

  state_t     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [3:0] score_left_q, score_left_d;
  logic [3:0] score_right_q, score_right_d;
  logic       serve_dir_q, serve_dir_d;
  logic [1:0] winner_q, winner_d;
  logic       paddle_en_q, paddle_en_d;
  logic       ball_en_q, ball_en_d;
  logic       ball_reset_q, ball_reset_d;
  logic       left_wins, right_wins;

`ifdef PONG_WIN_BY_TWO_EN
  // Five-bit compare so score+2 cannot overflow near the 4-bit ceiling.
  assign left_wins  = (score_left_q >= WIN4) &&
                      ({1'b0, score_left_q} >= ({1'b0, score_right_q} + 5'd2));
  assign right_wins = (score_right_q >= WIN4) &&
                      ({1'b0, score_right_q} >= ({1'b0, score_left_q} + 5'd2));
`else
  assign left_wins  = (score_left_q == WIN4);
  assign right_wins = (score_right_q == WIN4);
`endif

  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    score_left_d  = score_left_q;
    score_right_d = score_right_q;
    serve_dir_d   = serve_dir_q;
    winner_d      = winner_q;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d       = ST_SERVE;
          score_left_d  = 4'd0;
          score_right_d = 4'd0;
          winner_d      = 2'b00;
          serve_dir_d   = 1'b1;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (frame_cnt_q == SERVE_LAST) state_d = ST_PLAY;
          else frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      ST_PLAY: begin
        if (miss_left && miss_right) begin
          state_d = ST_SERVE;
        end else if (miss_left) begin
          score_right_d = score_right_q + 4'd1;
          serve_dir_d   = 1'b0;
          state_d       = ST_POINT;
        end else if (miss_right) begin
          score_left_d = score_left_q + 4'd1;
          serve_dir_d  = 1'b1;
          state_d      = ST_POINT;
        end
`ifdef PONG_WIN_BY_TWO_EN
        // Deuce: pull both back one point so scores stay within 4 bits.
        if (score_left_d == WIN4 && score_right_d == WIN4) begin
          score_left_d  = WIN4 - 4'd1;
          score_right_d = WIN4 - 4'd1;
        end
`endif
      end
      ST_POINT: begin
        if (frame_tick) begin
          if (frame_cnt_q == POINT_LAST) begin
            if (left_wins) begin
              state_d  = ST_OVER;
              winner_d = 2'b01;
            end else if (right_wins) begin
              state_d  = ST_OVER;
              winner_d = 2'b10;
            end else begin
              state_d = ST_SERVE;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) frame_cnt_d = 8'd0;

    // Enables are registered from the next state so they line up with the state output.
    paddle_en_d  = (state_d == ST_SERVE) || (state_d == ST_PLAY);
    ball_en_d    = (state_d == ST_PLAY);
    ball_reset_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      frame_cnt_q   <= 8'd0;
      score_left_q  <= 4'd0;
      score_right_q <= 4'd0;
      serve_dir_q   <= 1'b1;
      winner_q      <= 2'b00;
      paddle_en_q   <= 1'b0;
      ball_en_q     <= 1'b0;
      ball_reset_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
      serve_dir_q   <= serve_dir_d;
      winner_q      <= winner_d;
      paddle_en_q   <= paddle_en_d;
      ball_en_q     <= ball_en_d;
      ball_reset_q  <= ball_reset_d;
    end
  end

  assign paddle_en   = paddle_en_q;
  assign ball_en     = ball_en_q;
  assign ball_reset  = ball_reset_q;
  assign serve_dir   = serve_dir_q;
  assign score_left  = score_left_q;
  assign score_right = score_right_q;
  assign winner      = winner_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed self-checking bench for pong_match_ctrl at default parameters.
// The PONG_WIN_BY_TWO_EN section only runs when that macro is defined for the build.
module tb_pong_match_ctrl;

  localparam int SERVE_N = 60;
  localparam int POINT_N = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       frame_tick = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       paddle_en, ball_en, ball_reset, serve_dir;
  logic [3:0] score_left, score_right;
  logic [1:0] winner;
  logic [2:0] state;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  pong_match_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .frame_tick (frame_tick),
    .miss_left  (miss_left),
    .miss_right (miss_right),
    .paddle_en  (paddle_en),
    .ball_en    (ball_en),
    .ball_reset (ball_reset),
    .serve_dir  (serve_dir),
    .score_left (score_left),
    .score_right(score_right),
    .winner     (winner),
    .state      (state)
  );

  always #5 clk = ~clk;

  // One clock cycle of stimulus; inputs change 1 time unit after the edge, outputs are read there too.
  task automatic applyStimulus(input logic st, input logic ft, input logic ml, input logic mr);
    start      = st;
    frame_tick = ft;
    miss_left  = ml;
    miss_right = mr;
    @(posedge clk);
    #1;
    start      = 1'b0;
    frame_tick = 1'b0;
    miss_left  = 1'b0;
    miss_right = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) begin
      passes++;
    end else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // From PLAY: one miss, full POINT wait and full SERVE wait, ending back in PLAY.
  task automatic playPoint(input logic ml, input logic mr);
    applyStimulus(1'b0, 1'b0, ml, mr);
    runTicks(POINT_N);
    runTicks(SERVE_N);
    checkOutput("playpoint_state", 8'(state), 8'd2);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("rst_state", 8'(state), 8'd0);
    checkOutput("rst_paddle_en", 8'(paddle_en), 8'd0);
    checkOutput("rst_ball_en", 8'(ball_en), 8'd0);
    checkOutput("rst_ball_reset", 8'(ball_reset), 8'd0);
    checkOutput("rst_serve_dir", 8'(serve_dir), 8'd1);
    checkOutput("rst_score_l", 8'(score_left), 8'd0);
    checkOutput("rst_score_r", 8'(score_right), 8'd0);
    checkOutput("rst_winner", 8'(winner), 8'd0);

    // frame_tick in IDLE is ignored
    runTicks(3);
    checkOutput("idle_tick_state", 8'(state), 8'd0);

    // start with a coincident tick: that tick must not count toward SERVE
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("start_state", 8'(state), 8'd1);
    checkOutput("start_ball_reset", 8'(ball_reset), 8'd1);
    checkOutput("start_paddle_en", 8'(paddle_en), 8'd1);
    checkOutput("start_ball_en", 8'(ball_en), 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("serve_ball_reset_off", 8'(ball_reset), 8'd0);
    runTicks(SERVE_N - 2);
    checkOutput("serve_59_state", 8'(state), 8'd1);
    runTicks(1);
    checkOutput("serve_60_state", 8'(state), 8'd2);
    checkOutput("play_ball_en", 8'(ball_en), 8'd1);
    checkOutput("play_paddle_en", 8'(paddle_en), 8'd1);

    // frame_tick and start in PLAY are ignored
    runTicks(4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("play_ignore_state", 8'(state), 8'd2);

    // miss_left: right scores, serve toward left
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("missl_state", 8'(state), 8'd3);
    checkOutput("missl_score_r", 8'(score_right), 8'd1);
    checkOutput("missl_score_l", 8'(score_left), 8'd0);
    checkOutput("missl_serve_dir", 8'(serve_dir), 8'd0);
    checkOutput("point_paddle_en", 8'(paddle_en), 8'd0);
    checkOutput("point_ball_en", 8'(ball_en), 8'd0);

    // misses during POINT are ignored
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("point_miss_score_l", 8'(score_left), 8'd0);
    checkOutput("point_miss_state", 8'(state), 8'd3);
    runTicks(POINT_N - 1);
    checkOutput("point_29_state", 8'(state), 8'd3);
    runTicks(1);
    checkOutput("point_30_state", 8'(state), 8'd1);
    checkOutput("point_30_ball_reset", 8'(ball_reset), 8'd1);
    checkOutput("point_30_serve_dir", 8'(serve_dir), 8'd0);

    // misses and start during SERVE are ignored
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("serve_miss_score_l", 8'(score_left), 8'd0);
    checkOutput("serve_miss_score_r", 8'(score_right), 8'd1);
    checkOutput("serve_start_ball_reset", 8'(ball_reset), 8'd0);
    runTicks(SERVE_N - 1);
    // miss coincident with the final SERVE tick is ignored
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("final_tick_miss_state", 8'(state), 8'd2);
    checkOutput("final_tick_miss_score_r", 8'(score_right), 8'd1);

    // Simultaneous misses: replay with no score change
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("dbl_state", 8'(state), 8'd1);
    checkOutput("dbl_score_l", 8'(score_left), 8'd0);
    checkOutput("dbl_score_r", 8'(score_right), 8'd1);
    checkOutput("dbl_serve_dir", 8'(serve_dir), 8'd0);
    checkOutput("dbl_ball_reset", 8'(ball_reset), 8'd1);
    runTicks(SERVE_N);
    checkOutput("dbl_back_play", 8'(state), 8'd2);

    // Left wins 7-1 through full serve/point cycles
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("run_score_l", 8'(score_left), 8'(i));
      checkOutput("run_serve_dir", 8'(serve_dir), 8'd1);
      runTicks(POINT_N);
      if (i < 7) begin
        checkOutput("run_serve_state", 8'(state), 8'd1);
        checkOutput("run_winner_none", 8'(winner), 8'd0);
        runTicks(SERVE_N);
      end
    end
    checkOutput("over_state", 8'(state), 8'd4);
    checkOutput("over_winner", 8'(winner), 8'd1);
    checkOutput("over_score_l", 8'(score_left), 8'd7);
    checkOutput("over_score_r", 8'(score_right), 8'd1);
    checkOutput("over_paddle_en", 8'(paddle_en), 8'd0);

    // OVER holds scores against ticks and misses
    runTicks(5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("over_hold_state", 8'(state), 8'd4);
    checkOutput("over_hold_score_l", 8'(score_left), 8'd7);

    // start from OVER clears the match
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("restart_state", 8'(state), 8'd1);
    checkOutput("restart_score_l", 8'(score_left), 8'd0);
    checkOutput("restart_score_r", 8'(score_right), 8'd0);
    checkOutput("restart_winner", 8'(winner), 8'd0);
    checkOutput("restart_ball_reset", 8'(ball_reset), 8'd1);
    runTicks(SERVE_N);

    // Build a 3-2 score, then reset mid-PLAY with a miss pending
    playPoint(1'b0, 1'b1);
    playPoint(1'b0, 1'b1);
    playPoint(1'b0, 1'b1);
    playPoint(1'b1, 1'b0);
    playPoint(1'b1, 1'b0);
    checkOutput("pre_rst_score_l", 8'(score_left), 8'd3);
    checkOutput("pre_rst_score_r", 8'(score_right), 8'd2);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    checkOutput("midrst_state", 8'(state), 8'd0);
    checkOutput("midrst_score_l", 8'(score_left), 8'd0);
    checkOutput("midrst_score_r", 8'(score_right), 8'd0);
    checkOutput("midrst_paddle_en", 8'(paddle_en), 8'd0);
    checkOutput("midrst_ball_en", 8'(ball_en), 8'd0);
    checkOutput("midrst_serve_dir", 8'(serve_dir), 8'd1);

`ifdef PONG_WIN_BY_TWO_EN
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(SERVE_N);
    for (int i = 0; i < 6; i++) begin
      playPoint(1'b0, 1'b1);
      playPoint(1'b1, 1'b0);
    end
    checkOutput("wb2_66_l", 8'(score_left), 8'd6);
    checkOutput("wb2_66_r", 8'(score_right), 8'd6);
    playPoint(1'b1, 1'b0);
    checkOutput("wb2_67_r", 8'(score_right), 8'd7);
    checkOutput("wb2_67_winner", 8'(winner), 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("wb2_deuce_l", 8'(score_left), 8'd6);
    checkOutput("wb2_deuce_r", 8'(score_right), 8'd6);
    runTicks(POINT_N);
    runTicks(SERVE_N);
    playPoint(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("wb2_86_r", 8'(score_right), 8'd8);
    runTicks(POINT_N);
    checkOutput("wb2_over_state", 8'(state), 8'd4);
    checkOutput("wb2_over_winner", 8'(winner), 8'd2);
`endif

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer for the Pong design. It gates the paddle and ball datapaths through a serve / play / point / game-over state machine. It keeps both players' scores and decides the winner. It sits between the debounced start button, the frame-tick clock divider, the two paddle controllers and the ball engine.

## Interface
Parameters:
- WIN_SCORE, 7: points needed to win; legal range 1–14.
- SERVE_FRAMES, 60: frame ticks spent in SERVE before the ball is released; legal range ≥1, fits 8 bits.
- POINT_FRAMES, 30: frame ticks spent in POINT after a miss; legal range ≥1, fits 8 bits.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: debounced one-cycle start pulse.
- frame_tick, input, 1: one-cycle pulse per frame, from clockDivider.
- miss_left, input, 1: pulse; the ball passed the left paddle.
- miss_right, input, 1: pulse; the ball passed the right paddle.
- paddle_en, output, 1: enable to both paddle controllers.
- ball_en, output, 1: ball motion enable.
- ball_reset, output, 1: one-cycle pulse; re-centre the ball.
- serve_dir, output, 1: 0 serves toward left, 1 toward right.
- score_left, output, 4: left player score.
- score_right, output, 4: right player score.
- winner, output, 2: 00 none, 01 left, 10 right.
- state, output, 3: current state, for debug and display.

## Operation
- State encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4. All outputs are registered.
- IDLE: paddle_en=0, ball_en=0.
  - start → SERVE.
  - Scores are cleared, winner=00 and serve_dir=1 on this transition.
- SERVE:
  - ball_reset is high for exactly the first cycle in SERVE.
  - paddle_en=1, ball_en=0.
  - Counts frame_tick pulses. On the SERVE_FRAMES-th tick → PLAY.
- PLAY: paddle_en=1, ball_en=1.
  - miss_left alone: score_right+1, serve_dir=0, → POINT.
  - miss_right alone: score_left+1, serve_dir=1, → POINT.
  - miss_left and miss_right in the same cycle: no score change, serve_dir unchanged, → SERVE (replay).
- POINT: paddle_en=0, ball_en=0.
  - On the POINT_FRAMES-th tick, if the win condition holds → OVER, otherwise → SERVE.
- OVER: paddle_en=0, ball_en=0.
  - winner is set on entry and scores are held.
  - start → SERVE, with scores cleared, winner=00 and serve_dir=1.
- Win condition (default): a player's score equals WIN_SCORE.
- Ignored inputs:
  - miss_* outside PLAY.
  - start outside IDLE/OVER.
  - frame_tick in IDLE, PLAY and OVER.
- The frame counter is 8 bits. It clears on every state entry and never wraps within a legal parameter range.

## Timing
- Reset values: state=IDLE, paddle_en=0, ball_en=0, ball_reset=0, serve_dir=1, score_left=0, score_right=0, winner=00, frame counter=0.
- Reset mid-match returns to IDLE on the next edge and overrides all other inputs.
- start at edge N:
  - state=SERVE and ball_reset=1 after edge N.
  - ball_reset=0 after edge N+1.
- miss at edge N: the score, serve_dir and state=POINT are all visible after edge N. Latency is one cycle.
- The final frame_tick at edge N causes the transition after edge N.
- A frame_tick coincident with a state entry does not count toward the new state.
- A miss coinciding with the final SERVE tick is ignored, because the state is still SERVE.

## Configuration
- PONG_WIN_BY_TWO_EN, when defined:
  - The win condition becomes: score ≥ WIN_SCORE and lead ≥ 2.
  - If both scores reach WIN_SCORE simultaneously (deuce), both are set to WIN_SCORE−1 on the same edge, so scores never exceed WIN_SCORE+1 and fit 4 bits.
- PONG_WIN_BY_TWO_EN, when undefined: the first player to reach WIN_SCORE wins and scores never exceed WIN_SCORE.

## Test plan
- Reset, then start, then 60 frame_ticks (defaults) → ball_reset pulses exactly 1 cycle; state=PLAY right after the 60th tick; ball_en=1.
- In PLAY, miss_left → score_right=1, serve_dir=0, state=POINT next cycle; after 30 ticks → SERVE with a new ball_reset pulse.
- Drive 7 miss_right pulses through full serve/point cycles → score_left=7, winner=01, state=OVER; a further start clears the scores and gives state=SERVE.
- miss_left and miss_right in the same PLAY cycle → scores unchanged, state=SERVE; miss pulses during POINT and SERVE → no score change.
- Assert reset in PLAY with score 3–2 → next cycle IDLE, scores 0, all enables 0.
- With PONG_WIN_BY_TWO_EN, reach 6–6 then right scores → 7–6, no winner; left scores → scores become 6–6; right scores twice → 8–6, winner=10.
